// File: rtl/sonar_pkg.sv
// sonar_pkg: shared types and constants for the sonar distance filter.
//   ECHO_W     - width of a raw echo count from the sonar controller
//   DIST_W     - width of a filtered distance in millimetres
//   NO_ECHO    - substitute stored for a zero (no echo) count
//   DIST_RESET - distance reported before any update (far)
//   state_t    - filter FSM states; the MEDIAN state exists only when
//                SONAR_MEDIAN_EN is defined.
package sonar_pkg;

  localparam int ECHO_W = 20;
  localparam int DIST_W = 12;

  localparam logic [ECHO_W-1:0] NO_ECHO    = 20'hFFFFF;
  localparam logic [DIST_W-1:0] DIST_RESET = 12'd4095;

`ifdef SONAR_MEDIAN_EN
  typedef enum logic [1:0] {S_IDLE, S_MEDIAN, S_SCALE, S_COMPARE} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_SCALE, S_COMPARE} state_t;
`endif

endpackage

// File: rtl/sonar_distance_filter_median3.sv
// median3: combinational median of three unsigned echo counts.
// Compiled only when SONAR_MEDIAN_EN is defined (the only user).
//   a, b, c - echo counts (ECHO_W)
//   m       - median of a, b, c (ECHO_W)
`ifdef SONAR_MEDIAN_EN
module median3
  import sonar_pkg::*;
(
  input  logic [ECHO_W-1:0] a,
  input  logic [ECHO_W-1:0] b,
  input  logic [ECHO_W-1:0] c,
  output logic [ECHO_W-1:0] m
);

  logic [ECHO_W-1:0] lo_ab, hi_ab, lo_hc;

  always_comb begin
    lo_ab = (a < b) ? a : b;
    hi_ab = (a < b) ? b : a;
    lo_hc = (hi_ab < c) ? hi_ab : c;
    // median = max(min(a,b), min(max(a,b), c))
    m     = (lo_ab > lo_hc) ? lo_ab : lo_hc;
  end

endmodule
`endif

// File: rtl/sonar_distance_filter.sv
// sonar_distance_filter: turns the three-sonar controller's echo counts into
// filtered millimetre distances plus per-sonar near-obstacle flags.
// Build option SONAR_MEDIAN_EN: when defined, each sonar keeps a 3-sample
// history that is median-filtered before scaling; when undefined the
// captured count is scaled directly.
// Ports:
//   clk, reset         - clock, asynchronous active-high reset
//   T1, T2, T3         - controller trigger lines; a rise marks a fresh R
//                        (T1 -> R3, T2 -> R1, T3 -> R2)
//   R1, R2, R3         - latched echo counts (ECHO_W)
//   dist1..dist3       - filtered distances in mm (DIST_W), reset 4095
//   near               - bit i-1 = sonar i obstacle flag with hysteresis
//   valid              - one-cycle strobe on each dist/near update
//   sel                - sonar index (1..3) updated with valid
module sonar_distance_filter
  import sonar_pkg::*;
#(
  parameter int unsigned SCALE_K     = 225,
  parameter int unsigned SCALE_SHIFT = 16,
  parameter int unsigned NEAR_MM     = 300,
  parameter int unsigned FAR_MM      = 350
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              T1,
  input  logic              T2,
  input  logic              T3,
  input  logic [ECHO_W-1:0] R1,
  input  logic [ECHO_W-1:0] R2,
  input  logic [ECHO_W-1:0] R3,
  output logic [DIST_W-1:0] dist1,
  output logic [DIST_W-1:0] dist2,
  output logic [DIST_W-1:0] dist3,
  output logic [2:0]        near,
  output logic              valid,
  output logic [1:0]        sel
);

  localparam logic [DIST_W-1:0] NEAR_D = DIST_W'(NEAR_MM);
  localparam logic [DIST_W-1:0] FAR_D  = DIST_W'(FAR_MM);
  localparam int                PROD_W = ECHO_W + 32;

  // count * SCALE_K >> SCALE_SHIFT, saturated to the distance range
  function automatic logic [DIST_W-1:0] scale_mm(input logic [ECHO_W-1:0] e);
    logic [PROD_W-1:0] prod;
    logic [PROD_W-1:0] q;
    prod = PROD_W'(e) * PROD_W'(SCALE_K);
    q    = prod >> SCALE_SHIFT;
    if (q > PROD_W'({DIST_W{1'b1}}))
      return {DIST_W{1'b1}};
    return q[DIST_W-1:0];
  endfunction

  // set below NEAR_MM, clear at or above FAR_MM, hold in between
  function automatic logic hyst(input logic cur, input logic [DIST_W-1:0] d);
    if (d < NEAR_D)
      return 1'b1;
    if (d >= FAR_D)
      return 1'b0;
    return cur;
  endfunction

  logic [3:1]        t_now, t_q, rise, fresh, pending, grant_oh;
  logic [1:0]        grant, sel_p0;
  logic              cap;
  logic [ECHO_W-1:0] r_mux, sample;
  logic [ECHO_W-1:0] filt_p1;
  logic [DIST_W-1:0] dist_p2;
  state_t            state, state_nxt;

  assign t_now = {T3, T2, T1};
  assign rise  = t_now & ~t_q;
  // The controller latches R3/R1/R2 on the edges raising T1/T2/T3.
  assign fresh = {rise[1], rise[3], rise[2]};

  // Lowest pending index wins.
  always_comb begin
    grant    = 2'd0;
    grant_oh = 3'b000;
    r_mux    = R1;
    if (pending[1]) begin
      grant = 2'd1; grant_oh = 3'b001; r_mux = R1;
    end else if (pending[2]) begin
      grant = 2'd2; grant_oh = 3'b010; r_mux = R2;
    end else if (pending[3]) begin
      grant = 2'd3; grant_oh = 3'b100; r_mux = R3;
    end
  end

  assign sample = (r_mux == '0) ? NO_ECHO : r_mux;

  always_comb begin
    state_nxt = state;
    cap       = 1'b0;
    case (state)
      S_IDLE: begin
        if (|pending) begin
          cap = 1'b1;
`ifdef SONAR_MEDIAN_EN
          state_nxt = S_MEDIAN;
`else
          state_nxt = S_SCALE;
`endif
        end
      end
`ifdef SONAR_MEDIAN_EN
      S_MEDIAN:  state_nxt = S_SCALE;
`endif
      S_SCALE:   state_nxt = S_COMPARE;
      S_COMPARE: state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // p0: edge detect, pending mask, capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      t_q     <= 3'b000;
      pending <= 3'b000;
      sel_p0  <= 2'd0;
    end else begin
      state   <= state_nxt;
      t_q     <= t_now;
      // a rise landing on the bit being served re-arms it (newer sample)
      pending <= (pending & ~(cap ? grant_oh : 3'b000)) | fresh;
      if (cap)
        sel_p0 <= grant;
    end
  end

`ifdef SONAR_MEDIAN_EN
  logic [2:0][ECHO_W-1:0] hist [1:3];
  logic [2:0][ECHO_W-1:0] hist_cur;
  logic [ECHO_W-1:0]      med;

  always_comb begin
    case (sel_p0)
      2'd2:    hist_cur = hist[2];
      2'd3:    hist_cur = hist[3];
      default: hist_cur = hist[1];
    endcase
  end

  median3 u_median3 (
    .a (hist_cur[0]),
    .b (hist_cur[1]),
    .c (hist_cur[2]),
    .m (med)
  );

  // p1: history shift on capture, median register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 1; i <= 3; i++)
        hist[i] <= {3{NO_ECHO}};
      filt_p1 <= NO_ECHO;
    end else begin
      for (int i = 1; i <= 3; i++)
        if (cap && grant_oh[i])
          hist[i] <= {hist[i][1:0], sample};
      if (state == S_MEDIAN)
        filt_p1 <= med;
    end
  end
`else
  // p1: single-sample history
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      filt_p1 <= NO_ECHO;
    else if (cap)
      filt_p1 <= sample;
  end
`endif

  // p2: scale to millimetres
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      dist_p2 <= DIST_RESET;
    else if (state == S_SCALE)
      dist_p2 <= scale_mm(filt_p1);
  end

  // output stage: write served sonar, hysteresis, strobe
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dist1 <= DIST_RESET;
      dist2 <= DIST_RESET;
      dist3 <= DIST_RESET;
      near  <= 3'b000;
      valid <= 1'b0;
      sel   <= 2'd0;
    end else begin
      valid <= (state == S_COMPARE);
      if (state == S_COMPARE) begin
        sel <= sel_p0;
        case (sel_p0)
          2'd1: begin dist1 <= dist_p2; near[0] <= hyst(near[0], dist_p2); end
          2'd2: begin dist2 <= dist_p2; near[1] <= hyst(near[1], dist_p2); end
          2'd3: begin dist3 <= dist_p2; near[2] <= hyst(near[2], dist_p2); end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sonar_distance_filter.sv
// Directed bench for sonar_distance_filter. Expected distances are
// count*225>>16 worked by hand:
//   0xFFFFF -> 3599, 58000 -> 199, 93200 -> 319, 104860 -> 360, 20000 -> 68
module tb_sonar_distance_filter;

  logic        clk = 1'b0;
  logic        reset;
  logic        T1, T2, T3;
  logic [19:0] R1, R2, R3;
  logic [11:0] dist1, dist2, dist3;
  logic [2:0]  near;
  logic        valid;
  logic [1:0]  sel;

  int nvec  = 0;
  int nfail = 0;

`ifdef SONAR_MEDIAN_EN
  localparam bit MED = 1'b1;
  localparam int LAT = 4;
`else
  localparam bit MED = 1'b0;
  localparam int LAT = 3;
`endif

  always #10 clk = ~clk;

  sonar_distance_filter dut (
    .clk   (clk),
    .reset (reset),
    .T1    (T1),
    .T2    (T2),
    .T3    (T3),
    .R1    (R1),
    .R2    (R2),
    .R3    (R3),
    .dist1 (dist1),
    .dist2 (dist2),
    .dist3 (dist3),
    .near  (near),
    .valid (valid),
    .sel   (sel)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] dist_of(input logic [1:0] s);
    case (s)
      2'd1:    return dist1;
      2'd2:    return dist2;
      2'd3:    return dist3;
      default: return 12'd0;
    endcase
  endfunction

  // t = {T3,T2,T1}; the rise is detected at the next posedge (cycle 0),
  // returns at the negedge following it.
  task automatic fire(input logic [2:0] t);
    @(negedge clk); {T3, T2, T1} = t;
    @(negedge clk); {T3, T2, T1} = 3'b000;
  endtask

  // Waits for valid, counting edges since the previous reference point.
  task automatic expect_upd(input string tag, input int lat, input logic [1:0] esel,
                            input logic [11:0] edist, input logic [2:0] enear);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!valid && k < 40);
    chk({tag, "_lat"},  k, lat);
    chk({tag, "_sel"},  {30'd0, sel}, {30'd0, esel});
    chk({tag, "_dist"}, {20'd0, dist_of(esel)}, {20'd0, edist});
    chk({tag, "_near"}, {29'd0, near}, {29'd0, enear});
  endtask

  initial begin
    int vcnt;
    reset = 1'b1;
    {T3, T2, T1} = 3'b000;
    R1 = '0; R2 = '0; R3 = '0;
    repeat (3) @(negedge clk);
    chk("rst_dist1", dist1, 12'd4095);
    chk("rst_dist2", dist2, 12'd4095);
    chk("rst_dist3", dist3, 12'd4095);
    chk("rst_near",  near,  3'b000);
    chk("rst_valid", valid, 1'b0);
    chk("rst_sel",   sel,   2'd0);
    reset = 1'b0;
    @(negedge clk);

    // sonar 1 via T2: near approach, then hysteresis band, then far
    R1 = 20'd58000;
    fire(3'b010);
    expect_upd("s1a", LAT, 2'd1, MED ? 12'd3599 : 12'd199, MED ? 3'b000 : 3'b001);
    chk("s1a_d2_hold", dist2, 12'd4095);
    chk("s1a_d3_hold", dist3, 12'd4095);
    fire(3'b010);
    expect_upd("s1b", LAT, 2'd1, 12'd199, 3'b001);
    R1 = 20'd93200;
    fire(3'b010);
    expect_upd("s1c", LAT, 2'd1, MED ? 12'd199 : 12'd319, 3'b001);
    fire(3'b010);
    expect_upd("s1d", LAT, 2'd1, 12'd319, 3'b001);
    R1 = 20'd104860;
    fire(3'b010);
    expect_upd("s1e", LAT, 2'd1, MED ? 12'd319 : 12'd360, MED ? 3'b001 : 3'b000);
    fire(3'b010);
    expect_upd("s1f", LAT, 2'd1, 12'd360, 3'b000);

    // simultaneous rise: served 1, 2, 3, each LAT cycles apart
    R2 = 20'd58000;
    R3 = 20'd20000;
    fire(3'b111);
    expect_upd("t1s1", LAT, 2'd1, 12'd360, 3'b000);
    expect_upd("t1s2", LAT, 2'd2, MED ? 12'd3599 : 12'd199, MED ? 3'b000 : 3'b010);
    expect_upd("t1s3", LAT, 2'd3, MED ? 12'd3599 : 12'd68,  MED ? 3'b000 : 3'b110);

    // zero count on sonar 2 reads as no echo
    R2 = 20'd0;
    fire(3'b100);
    expect_upd("zero", LAT, 2'd2, 12'd3599, MED ? 3'b000 : 3'b100);

    R2 = 20'd58000;
    fire(3'b111);
    expect_upd("t2s1", LAT, 2'd1, 12'd360, MED ? 3'b000 : 3'b100);
    expect_upd("t2s2", LAT, 2'd2, 12'd199, MED ? 3'b010 : 3'b110);
    expect_upd("t2s3", LAT, 2'd3, 12'd68,  3'b110);

    // reset in the cycle after capture discards the in-flight sample
    R1 = 20'd58000;
    fire(3'b010);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_dist1", dist1, 12'd4095);
    chk("mid_rst_near",  near,  3'b000);
    reset = 1'b0;
    vcnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (valid) vcnt++;
    end
    chk("mid_rst_novalid", vcnt, 0);
    chk("mid_rst_dist1b", dist1, 12'd4095);
    chk("mid_rst_dist2",  dist2, 12'd4095);
    chk("mid_rst_dist3",  dist3, 12'd4095);
    chk("mid_rst_sel",    sel,   2'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
